// File: rtl/cmd_bus_arbiter_pkg.sv
// Shared definitions for the command-bus arbiter: default bus widths, FSM encoding
// and the turnaround counter load helper.
package cmd_bus_arbiter_pkg;

    localparam int CMD_AW = 19;
    localparam int CMD_DW = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Cycles spent in HOLD after the strobe: write turnaround or read latency.
    function automatic logic [CNT_W-1:0] turn_load(input logic is_wr,
                                                   input int   wr_gap,
                                                   input int   rd_lat);
        return is_wr ? CNT_W'(wr_gap) : CNT_W'(rd_lat);
    endfunction

endpackage

// File: rtl/cmd_bus_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping, returned as an index plus a valid flag.
module cmd_bus_arbiter_rr #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable gets a default before the loop so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int j = 0; j < NREQ; j++) begin
            sum  = {1'b0, ptr_i} + (IDX_W+1)'(j);
            cand = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ)) : IDX_W'(sum);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Shares the command bus between NREQ masters: round-robin pick, one transaction in
// flight, write turnaround and read latency enforced by a small down-counter.
module cmd_bus_arbiter
    import cmd_bus_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int AW     = CMD_AW,
    parameter int DW     = CMD_DW,
    parameter int WR_GAP = 1,
    parameter int RD_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_wr_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic [DW-1:0]      rdata_o,
    output logic [AW-1:0]      cmd_bus_addr_o,
    output logic [DW-1:0]      cmd_bus_data_o,
    output logic               cmd_bus_en_o,
    output logic               cmd_bus_rd_o,
    output logic               cmd_bus_wr_o,
    input  logic [DW-1:0]      cmd_bus_rdata_i
);

    localparam int IDX_W = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [AW-1:0]     addr_arr [NREQ];
    logic [DW-1:0]     data_arr [NREQ];
    logic [CNT_W-1:0]  load;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*AW +: AW];
        assign data_arr[g] = req_wdata_i[g*DW +: DW];
    end

    cmd_bus_arbiter_rr #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign load = turn_load(op_q, WR_GAP, RD_LAT);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    op_d    = req_wr_i[arb_idx];
                    addr_d  = addr_arr[arb_idx];
                    data_d  = data_arr[arb_idx];
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                cnt_d   = load;
                state_d = (load == '0) ? ST_DONE : ST_HOLD;
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    // Last HOLD cycle is exactly RD_LAT after the strobe.
                    if (!op_q) begin
                        rdata_d = cmd_bus_rdata_i;
                    end
                end
            end
            ST_DONE: begin
                ptr_d   = (win_q == IDX_W'(NREQ-1)) ? '0 : win_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode registered state only; an async reset clears them at once.
    logic             busy;
    logic             strobe;
    logic [NREQ-1:0]  win_onehot;

    assign busy       = (state_q != ST_IDLE);
    assign strobe     = (state_q == ST_STROBE);
    assign win_onehot = NREQ'(1) << win_q;

    assign gnt_o          = busy ? win_onehot : '0;
    assign done_o         = (state_q == ST_DONE) ? win_onehot : '0;
    assign rdata_o        = rdata_q;
    assign cmd_bus_addr_o = busy ? addr_q : '0;
    assign cmd_bus_data_o = busy ? data_q : '0;
    assign cmd_bus_en_o   = strobe;
    assign cmd_bus_wr_o   = strobe & op_q;
    assign cmd_bus_rd_o   = strobe & ~op_q;

endmodule
